// File: rtl/mac_result_drain_if.sv
// Handshake bundle between the MAC grid controller, the result drain and its consumer.
// The drain itself connects through the slave modport.
interface mac_result_drain_if #(
  parameter int COLS  = 16,
  parameter int ACC_W = 17,
  parameter int OUT_W = 8
);
  localparam int IDX_W = $clog2(COLS);

  logic                  capture;
  logic [COLS*ACC_W-1:0] acc_in;
  logic [COLS-1:0]       col_mask;
  logic [4:0]            shift;
  logic [OUT_W-1:0]      out_data;
  logic [IDX_W-1:0]      out_col;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  cap_ready;
  logic                  drop_err;

  modport master (
    output capture, acc_in, col_mask, shift, out_ready,
    input  out_data, out_col, out_last, out_valid, cap_ready, drop_err
  );

  modport slave (
    input  capture, acc_in, col_mask, shift, out_ready,
    output out_data, out_col, out_last, out_valid, cap_ready, drop_err
  );
endinterface

// File: rtl/mac_result_drain.sv
// Ping-pong snapshot of the MAC column accumulators, requantised to OUT_W bits and streamed one column per beat.
// Define MAC_DRAIN_RELU_EN to clamp negative results to zero after saturation.
module mac_result_drain #(
  parameter int COLS  = 16,
  parameter int ACC_W = 17,
  parameter int OUT_W = 8
) (
  input logic               Clk,
  input logic               reset,
  mac_result_drain_if.slave bus
);
  localparam int IDX_W = $clog2(COLS);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2**(OUT_W-1)));

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] bank_acc   [2][COLS];
  logic [COLS-1:0]         bank_mask  [2];
  logic [4:0]              bank_shift [2];
  logic [1:0]              bank_full;
  logic                    wr_ptr;
  logic                    rd_ptr;

  logic [OUT_W-1:0] out_data_r;
  logic [IDX_W-1:0] out_col_r;
  logic             out_last_r;
  logic             out_valid_r;
  logic             cap_ready_r;
  logic             drop_err_r;

  logic             hs;
  logic             load;
  logic             finish;
  logic             other_ptr;
  logic             sel_bank;
  logic [COLS-1:0]  cur_rem;
  logic [COLS-1:0]  sel_mask;
  logic [IDX_W-1:0] pick;
  logic [OUT_W-1:0] pick_data;
  logic             pick_last;
  logic             cap_take;
  logic             cap_drop;
  logic [1:0]       full_next;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [COLS-1:0] m);
    lowest_set = '0;
    for (int k = COLS - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = IDX_W'(k);
    end
  endfunction

  // Round half up, arithmetic shift, then saturate; the extra bit keeps the rounding add from overflowing.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc, input logic [4:0] sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;
    logic [OUT_W-1:0]      res;
    ext     = {acc[ACC_W-1], acc};
    rounded = (sh != 5'd0) ? ext + ((ACC_W+1)'(1) << (sh - 5'd1)) : ext;
    shifted = rounded >>> sh;
    if (shifted > SAT_HI)      res = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) res = SAT_LO[OUT_W-1:0];
    else                       res = shifted[OUT_W-1:0];
`ifdef MAC_DRAIN_RELU_EN
    if (res[OUT_W-1]) res = '0;
`endif
    return res;
  endfunction

  always_comb begin
    hs        = (state == PRESENT) && out_valid_r && bus.out_ready;
    other_ptr = ~rd_ptr;
    cur_rem   = bank_mask[rd_ptr] & ~(COLS'(1) << out_col_r);
    load      = 1'b0;
    finish    = 1'b0;
    sel_bank  = rd_ptr;
    sel_mask  = bank_mask[rd_ptr];
    if (state == IDLE) begin
      load = bank_full[rd_ptr];
    end else if (hs) begin
      if (cur_rem != '0) begin
        load     = 1'b1;
        sel_mask = cur_rem;
      end else begin
        // Bank exhausted: hand over straight to the other bank if it was already waiting.
        finish   = 1'b1;
        sel_bank = other_ptr;
        sel_mask = bank_mask[other_ptr];
        load     = bank_full[other_ptr];
      end
    end
    pick      = lowest_set(sel_mask);
    pick_data = requant(bank_acc[sel_bank][pick], bank_shift[sel_bank]);
    pick_last = (sel_mask & ~(COLS'(1) << pick)) == '0;

    cap_take  = bus.capture && (bus.col_mask != '0) && !(&bank_full);
    cap_drop  = bus.capture && (bus.col_mask != '0) && (&bank_full);
    full_next = bank_full;
    if (finish)   full_next[rd_ptr] = 1'b0;
    if (cap_take) full_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      bank_full   <= '0;
      out_data_r  <= '0;
      out_col_r   <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      cap_ready_r <= 1'b1;
      drop_err_r  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_mask[b]  <= '0;
        bank_shift[b] <= '0;
        for (int k = 0; k < COLS; k++) bank_acc[b][k] <= '0;
      end
    end else begin
      bank_full   <= full_next;
      cap_ready_r <= !(&full_next);
      if (cap_drop) drop_err_r <= 1'b1;
      if (hs)       bank_mask[rd_ptr] <= cur_rem;
      if (finish)   rd_ptr <= other_ptr;
      if (cap_take) begin
        for (int k = 0; k < COLS; k++) bank_acc[wr_ptr][k] <= bus.acc_in[k*ACC_W +: ACC_W];
        bank_mask[wr_ptr]  <= bus.col_mask;
        bank_shift[wr_ptr] <= (bus.shift > 5'd16) ? 5'd16 : bus.shift;
        wr_ptr             <= ~wr_ptr;
      end
      if (load) begin
        state       <= PRESENT;
        out_valid_r <= 1'b1;
        out_data_r  <= pick_data;
        out_col_r   <= pick;
        out_last_r  <= pick_last;
      end else if (finish) begin
        state       <= IDLE;
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_col   = out_col_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_valid = out_valid_r;
  assign bus.cap_ready = cap_ready_r;
  assign bus.drop_err  = drop_err_r;
endmodule
